// File: rtl/ps2_host_link.sv
// ps2_host_link: bidirectional PS/2 host controller for one port.
//
// The host sends a frame by inhibiting the bus, issuing a request-to-send,
// shifting out d0..d7, odd parity and stop, and then checking the device ACK.
// It receives device frames with start, parity and stop checking. A no-clock
// timeout supervises every transfer.
//
// Ports:
//   qzt_clk   system clock (single domain)
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, sampled when tx_send is accepted
//   tx_send   transmit request, accepted only while idle
//   busy      high whenever the link is not idle
//   tx_done   pulse: frame sent and ACKed
//   tx_err    pulse: transmit timeout or missing ACK
//   rx_data   last valid received byte
//   rx_valid  pulse: rx_data updated
//   rx_err    pulse: bad start/parity/stop or receive timeout
//   state_o   current FSM state (debug)
//   PS2C/PS2D open-drain clock and data pins (drive 0 or z only)
//
// Handshake: tx_send is level-sampled; a request is taken on a clock edge
// where the link is idle (busy=0) and tx_send=1. busy rises on the next
// cycle. Requests while busy=1 are dropped, never queued. Each status pulse
// lasts one cycle and coincides with busy falling.
module ps2_host_link #(
  parameter int INHIBIT_CYC = 5000,
  parameter int REQ_CYC     = 50,
  parameter int TIMEOUT_CYC = 750000,
  parameter int CNT_W       = 20
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [2:0] state_o,
  inout  wire        PS2C,
  inout  wire        PS2D
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_TX      = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RX      = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [10:0]      sh_q, sh_d;
  logic             c_low_q, c_low_d;
  logic             d_low_q, d_low_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_err_q, tx_err_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;

  // Synchronisers reset to 1 (idle bus level) so release never looks like an edge.
  logic c_s1_q, c_s2_q, c_prev_q;
  logic d_s1_q, d_s2_q;
  logic fe;
  logic timer_hit;
  logic [10:0] rx_frame;

  assign PS2C = c_low_q ? 1'b0 : 1'bz;
  assign PS2D = d_low_q ? 1'b0 : 1'bz;

  assign fe        = c_prev_q & ~c_s2_q;
  assign timer_hit = (timer_q == CNT_W'(TIMEOUT_CYC - 1));
  // Frame as it will look once the current data sample is shifted in.
  assign rx_frame  = {d_s2_q, sh_q[10:1]};

  assign busy     = (state_q != S_IDLE);
  assign tx_done  = tx_done_q;
  assign tx_err   = tx_err_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign state_o  = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    sh_d       = sh_q;
    c_low_d    = c_low_q;
    d_low_d    = d_low_q;
    rx_data_d  = rx_data_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        c_low_d = 1'b0;
        d_low_d = 1'b0;
        if (tx_send) begin
          // Bit 0 is shifted out first: d0..d7, odd parity, stop.
          sh_d    = {1'b0, 1'b1, ~^tx_data, tx_data};
          cnt_d   = 4'd0;
          timer_d = '0;
          c_low_d = 1'b1;
          state_d = S_INHIBIT;
        end else if (fe && !d_s2_q) begin
          sh_d    = rx_frame;
          cnt_d   = 4'd1;
          timer_d = '0;
          state_d = S_RX;
        end
      end

      S_INHIBIT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == CNT_W'(INHIBIT_CYC - 1)) begin
          timer_d = '0;
          d_low_d = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == CNT_W'(REQ_CYC - 1)) begin
          // PS2D stays low: it now acts as the start bit.
          timer_d = '0;
          c_low_d = 1'b0;
          state_d = S_TX;
        end
      end

      S_TX: begin
        if (fe) begin
          timer_d = '0;
          d_low_d = ~sh_q[0];
          sh_d    = {1'b0, sh_q[10:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 4'd9) begin
            cnt_d   = 4'd0;
            state_d = S_ACK;
          end
        end else if (timer_hit) begin
          tx_err_d = 1'b1;
          c_low_d  = 1'b0;
          d_low_d  = 1'b0;
          timer_d  = '0;
          cnt_d    = 4'd0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_ACK: begin
        if (fe) begin
          tx_done_d = ~d_s2_q;
          tx_err_d  = d_s2_q;
          d_low_d   = 1'b0;
          timer_d   = '0;
          state_d   = S_IDLE;
        end else if (timer_hit) begin
          tx_err_d = 1'b1;
          c_low_d  = 1'b0;
          d_low_d  = 1'b0;
          timer_d  = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RX: begin
        if (fe) begin
          timer_d = '0;
          sh_d    = rx_frame;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 4'd10) begin
            cnt_d = 4'd0;
            // Valid: start 0, stop 1, odd parity over data+parity.
            if (!rx_frame[0] && rx_frame[10] && (^rx_frame[9:1])) begin
              rx_data_d  = rx_frame[8:1];
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
            state_d = S_IDLE;
          end
        end else if (timer_hit) begin
          rx_err_d = 1'b1;
          timer_d  = '0;
          cnt_d    = 4'd0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        c_low_d = 1'b0;
        d_low_d = 1'b0;
        timer_d = '0;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      timer_q    <= '0;
      sh_q       <= 11'd0;
      c_low_q    <= 1'b0;
      d_low_q    <= 1'b0;
      rx_data_q  <= 8'h00;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      c_s1_q     <= 1'b1;
      c_s2_q     <= 1'b1;
      c_prev_q   <= 1'b1;
      d_s1_q     <= 1'b1;
      d_s2_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      sh_q       <= sh_d;
      c_low_q    <= c_low_d;
      d_low_q    <= d_low_d;
      rx_data_q  <= rx_data_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      c_s1_q     <= PS2C;
      c_s2_q     <= c_s1_q;
      c_prev_q   <= c_s2_q;
      d_s1_q     <= PS2D;
      d_s2_q     <= d_s1_q;
    end
  end

endmodule

// File: tb/tb_ps2_host_link.sv
// Directed testbench for ps2_host_link with a simple PS/2 device model.
module tb_ps2_host_link;

  localparam int I_CYC = 100;
  localparam int R_CYC = 10;
  localparam int T_CYC = 300;
  localparam int H     = 20;   // device clock half period in qzt_clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_data = 8'h00;
  logic       tx_send = 1'b0;
  logic       busy, tx_done, tx_err, rx_valid, rx_err;
  logic [7:0] rx_data;
  logic [2:0] state;

  wire ps2c_w;
  wire ps2d_w;
  pullup (ps2c_w);
  pullup (ps2d_w);

  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  assign ps2c_w = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d_w = dev_d_low ? 1'b0 : 1'bz;

  ps2_host_link #(
    .INHIBIT_CYC(I_CYC),
    .REQ_CYC    (R_CYC),
    .TIMEOUT_CYC(T_CYC),
    .CNT_W      (10)
  ) dut (
    .qzt_clk (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .busy    (busy),
    .tx_done (tx_done),
    .tx_err  (tx_err),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .state_o (state),
    .PS2C    (ps2c_w),
    .PS2D    (ps2d_w)
  );

  // ---------------- pulse monitors ----------------
  int   done_cnt = 0, terr_cnt = 0, rv_cnt = 0, rerr_cnt = 0, host_drv_cnt = 0;
  int   terr_cyc = -1;
  logic busy_at_pulse = 1'b1;
  always @(negedge clk) begin
    if (tx_done) begin done_cnt <= done_cnt + 1; busy_at_pulse <= busy; end
    if (tx_err) begin terr_cnt <= terr_cnt + 1; terr_cyc <= cyc; busy_at_pulse <= busy; end
    if (rx_valid) rv_cnt <= rv_cnt + 1;
    if (rx_err) rerr_cnt <= rerr_cnt + 1;
    if ((ps2c_w === 1'b0 && !dev_c_low) || (ps2d_w === 1'b0 && !dev_d_low))
      host_drv_cnt <= host_drv_cnt + 1;
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [7:0] b);
    tick(1);
    tx_data = b;
    tx_send = 1'b1;
    tick(1);
    tx_send = 1'b0;
  endtask

  // Counts host-held low cycles of PS2C/PS2D until PS2C is released.
  task automatic wait_release(output int clow, output int dlow, output int rel_cyc);
    clow = 0;
    dlow = 0;
    rel_cyc = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (ps2c_w !== 1'b0) begin
        rel_cyc = cyc;
        break;
      end
      clow++;
      if (ps2d_w === 1'b0) dlow++;
    end
    tick(1);
  endtask

  // Device clocks 10 bits in from the host, sampling PS2D on rising clock.
  task automatic dev_bits(output logic [9:0] bits);
    bits = '0;
    for (int i = 0; i < 10; i++) begin
      dev_c_low = 1'b1;
      tick(H);
      dev_c_low = 1'b0;
      bits[i] = (ps2d_w !== 1'b0);
      tick(H);
    end
  endtask

  task automatic dev_ack_clock(input logic ack);
    dev_d_low = ack;
    tick(H / 2);
    dev_c_low = 1'b1;
    tick(H);
    dev_c_low = 1'b0;
    tick(2);
    dev_d_low = 1'b0;
    tick(H);
  endtask

  task automatic dev_send(input logic [10:0] f);
    for (int i = 0; i < 11; i++) begin
      dev_d_low = ~f[i];
      tick(H / 2);
      dev_c_low = 1'b1;
      tick(H);
      dev_c_low = 1'b0;
      tick(H / 2);
    end
    dev_d_low = 1'b0;
    tick(H);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0] bits;
    int clow, dlow, rel, b_done, b_terr, b_rv, b_rerr, b_hd;
    logic seen;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_err", rx_err, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_ps2c", ps2c_w, 1);
    check("rst_ps2d", ps2d_w, 1);
    check("rst_state", state, 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // TX 0xF4 with ACK
    b_done = done_cnt; b_terr = terr_cnt;
    start_tx(8'hF4);
    wait_release(clow, dlow, rel);
    check("f4_ps2c_low_cycles", clow, I_CYC + R_CYC);
    check("f4_ps2d_req_cycles", dlow, R_CYC);
    dev_bits(bits);
    check("f4_bits", bits, 10'b10_1111_0100);
    dev_ack_clock(1'b1);
    check("f4_done_count", done_cnt - b_done, 1);
    check("f4_no_err", terr_cnt - b_terr, 0);
    check("f4_busy_at_done", busy_at_pulse, 0);
    check("f4_idle_after", busy, 0);

    // RX 0xFA valid frame
    b_rv = rv_cnt; b_rerr = rerr_cnt; b_hd = host_drv_cnt;
    dev_send(11'b1_1_11111010_0);
    check("rx_fa_valid", rv_cnt - b_rv, 1);
    check("rx_fa_no_err", rerr_cnt - b_rerr, 0);
    check("rx_fa_data", rx_data, 8'hFA);
    check("rx_fa_lines_free", host_drv_cnt - b_hd, 0);

    // RX 0xFA with bad parity
    b_rv = rv_cnt; b_rerr = rerr_cnt;
    dev_send(11'b1_0_11111010_0);
    check("rx_par_err", rerr_cnt - b_rerr, 1);
    check("rx_par_no_valid", rv_cnt - b_rv, 0);
    check("rx_par_data_kept", rx_data, 8'hFA);

    // TX 0xFF with no device: timeout
    b_done = done_cnt; b_terr = terr_cnt;
    start_tx(8'hFF);
    wait_release(clow, dlow, rel);
    check("ff_release_seen", (rel >= 0), 1);
    seen = 1'b0;
    for (int k = 0; k < T_CYC + 100; k++) begin
      @(negedge clk);
      if (tx_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("ff_err_seen", seen, 1);
    check("ff_ps2c_free", ps2c_w, 1);
    check("ff_ps2d_free", ps2d_w, 1);
    check("ff_busy_low", busy, 0);
    tick(1);
    check("ff_timeout_cycles", terr_cyc - rel, T_CYC);
    check("ff_no_done", done_cnt - b_done, 0);
    check("ff_one_err", terr_cnt - b_terr, 1);

    // TX 0x3C with missing ACK, then immediate new request
    start_tx(8'h3C);
    wait_release(clow, dlow, rel);
    dev_bits(bits);
    check("3c_bits", bits, 10'b11_0011_1100);
    b_done = done_cnt; b_terr = terr_cnt;
    tick(H / 2);
    dev_c_low = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("noack_err_seen", seen, 1);
    tx_data = 8'hF4;
    tx_send = 1'b1;
    @(negedge clk);
    tx_send = 1'b0;
    check("noack_next_accepted", busy, 1);
    tick(H);
    dev_c_low = 1'b0;
    check("noack_err_count", terr_cnt - b_terr, 1);
    check("noack_no_done", done_cnt - b_done, 0);
    wait_release(clow, dlow, rel);
    dev_bits(bits);
    check("retry_bits", bits, 10'b10_1111_0100);
    b_done = done_cnt;
    dev_ack_clock(1'b1);
    check("retry_done", done_cnt - b_done, 1);

    // Reset after 4 TX bits
    start_tx(8'hF4);
    wait_release(clow, dlow, rel);
    for (int i = 0; i < 4; i++) begin
      dev_c_low = 1'b1;
      tick(H);
      dev_c_low = 1'b0;
      bits[i] = (ps2d_w !== 1'b0);
      tick(H);
    end
    check("mid_bits", bits[3:0], 4'b0100);
    check("mid_ps2d_driven", ps2d_w, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ps2c", ps2c_w, 1);
    check("mid_rst_ps2d", ps2d_w, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_pulses", {tx_done, tx_err, rx_valid, rx_err}, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    b_done = done_cnt; b_terr = terr_cnt;
    start_tx(8'hF4);
    wait_release(clow, dlow, rel);
    check("post_rst_low_cycles", clow, I_CYC + R_CYC);
    dev_bits(bits);
    check("post_rst_bits", bits, 10'b10_1111_0100);
    dev_ack_clock(1'b1);
    check("post_rst_done", done_cnt - b_done, 1);
    check("post_rst_no_err", terr_cnt - b_terr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
